sub_bytes_serial: RTL and testbench

- Byte-serial SubBytes/InvSubBytes sequencer for the low-area AES core.
- Drives the single shared compact S-box (bSbox) one byte per clock and collects its outputs into a 128-bit result.
- Sits between the round-state register and bSbox: feeds bSbox inputs and consumes its combinational output.
- bSbox is instantiated by the parent, so the key schedule can time-share it using sbox_req.

---
 rtl/aes_pkg.sv | 14 +
 rtl/sub_bytes_serial.sv | 105 ++++++++++
 tb/tb_sub_bytes_serial.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the low-area AES core: state/byte types and the
// SubBytes sequencer state encoding.
package aes_pkg;

  localparam int AES_NBYTES = 16;

  typedef logic [8*AES_NBYTES-1:0] aes_state_t;
  typedef logic [7:0]              aes_byte_t;

  localparam logic [1:0] SB_IDLE = 2'd0;
  localparam logic [1:0] SB_RUN  = 2'd1;
  localparam logic [1:0] SB_DONE = 2'd2;

endpackage

// File: rtl/sub_bytes_serial.sv
// Byte-serial SubBytes/InvSubBytes sequencer driving the shared bSbox one byte per clock.
// Optional macro SUB_BYTES_SBOX_REG_EN registers sbox_q before it enters the result.
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  encrypt,
  input  logic [8*NBYTES-1:0]   state_in,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   state_out,
  output logic                  sbox_req,
  output logic [7:0]            sbox_a,
  output logic                  sbox_encrypt,
  input  logic [7:0]            sbox_q
);

  localparam int         W        = 8 * NBYTES;
  localparam logic [3:0] CNT_LAST = 4'(NBYTES - 1);

  logic [1:0]   r_fsm;
  logic [3:0]   r_cnt;
  logic [W-1:0] r_sr;
  logic [W-9:0] r_res;
  logic [W-1:0] r_out;
  logic         r_mode;

  aes_byte_t    w_resByte;
  logic         w_resEn;
  logic         w_last;

`ifdef SUB_BYTES_SBOX_REG_EN
  aes_byte_t    r_pipe;
  logic         r_fill;

  // The first RUN edge only primes the pipe; result capture starts one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
      r_fill <= 1'b0;
    end else if (r_fsm == SB_RUN) begin
      r_pipe <= sbox_q;
      r_fill <= 1'b1;
    end else if (r_fsm == SB_IDLE) begin
      r_fill <= 1'b0;
    end
  end

  assign w_resByte = r_pipe;
  assign w_resEn   = r_fill;
`else
  assign w_resByte = sbox_q;
  assign w_resEn   = 1'b1;
`endif

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm  <= SB_IDLE;
      r_cnt  <= '0;
      r_sr   <= '0;
      r_res  <= '0;
      r_out  <= '0;
      r_mode <= 1'b0;
    end else begin
      case (r_fsm)
        SB_IDLE: begin
          if (start) begin
            r_sr   <= state_in;
            r_mode <= encrypt;
            r_cnt  <= '0;
            r_fsm  <= SB_RUN;
          end
        end
        SB_RUN: begin
          r_sr <= r_sr << 8;
          if (w_resEn) begin
            r_res <= {r_res[W-17:0], w_resByte};
            r_cnt <= r_cnt + 4'd1;
            // r_res holds only the first NBYTES-1 bytes; the last one joins here.
            if (w_last) begin
              r_out <= {r_res, w_resByte};
              r_fsm <= SB_DONE;
            end
          end
        end
        SB_DONE: r_fsm <= SB_IDLE;
        default: r_fsm <= SB_IDLE;
      endcase
    end
  end

  assign busy         = (r_fsm == SB_RUN);
  assign done         = (r_fsm == SB_DONE);
  assign sbox_req     = busy;
  assign sbox_a       = busy ? r_sr[W-1 -: 8] : 8'h00;
  assign sbox_encrypt = r_mode;
  assign state_out    = r_out;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Scoreboard bench for sub_bytes_serial; stands in for bSbox with tables built
// from GF(2^8) arithmetic. Honours SUB_BYTES_SBOX_REG_EN for latency.
module tb_sub_bytes_serial;

`ifdef SUB_BYTES_SBOX_REG_EN
  localparam int LATENCY   = 18;
  localparam int RUNCYCLES = 17;
`else
  localparam int LATENCY   = 17;
  localparam int RUNCYCLES = 16;
`endif

  typedef struct {
    logic [127:0] data;
    int           doneCyc;
  } expItem_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         encrypt;
  logic [127:0] state_in;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
  logic         sbox_req;
  logic [7:0]   sbox_a;
  logic         sbox_encrypt;
  logic [7:0]   sbox_q;

  logic [7:0]   fwdTab [256];
  logic [7:0]   invTab [256];
  expItem_t     scoreboard [$];
  int           cyc = 0;
  int           busyCnt = 0;
  int           reqCnt = 0;
  int           errorCount = 0;
  int           checkCount = 0;

  sub_bytes_serial #(.NBYTES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .encrypt      (encrypt),
    .state_in     (state_in),
    .busy         (busy),
    .done         (done),
    .state_out    (state_out),
    .sbox_req     (sbox_req),
    .sbox_a       (sbox_a),
    .sbox_encrypt (sbox_encrypt),
    .sbox_q       (sbox_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational stand-in for the shared bSbox instance.
  assign sbox_q = sbox_encrypt ? fwdTab[sbox_a] : invTab[sbox_a];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return (x == 8'h00) ? 8'h00 : r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] r1, r2, r3, r4;
    r1 = rotl(b);
    r2 = rotl(r1);
    r3 = rotl(r2);
    r4 = rotl(r3);
    return b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) fwdTab[x] = affine(gfInv(8'(x)));
    for (int x = 0; x < 256; x++) invTab[fwdTab[x]] = 8'(x);
  end

  function automatic logic [127:0] refSubBytes(input logic [127:0] d, input logic enc);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = d[127-8*i -: 8];
      r[127-8*i -: 8] = enc ? fwdTab[b] : invTab[b];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, enforces reset values and timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("resetControls", 128'({busy, done, sbox_req, sbox_encrypt, sbox_a}), '0);
      checkOutput("resetStateOut", state_out, '0);
      scoreboard.delete();
      busyCnt = 0;
      reqCnt  = 0;
    end else begin
      if (!sbox_req) checkOutput("sboxAIdle", 128'(sbox_a), '0);
      if (busy) busyCnt++;
      if (sbox_req) reqCnt++;
      if (done) begin
        if (scoreboard.size() == 0) begin
          checkOutput("unexpectedDone", 128'(done), '0);
        end else begin
          expItem_t e;
          e = scoreboard.pop_front();
          checkOutput("stateOut", state_out, e.data);
          checkOutput("doneCycle", 128'(cyc), 128'(e.doneCyc));
          checkOutput("busyCycles", 128'(busyCnt), 128'(RUNCYCLES));
          checkOutput("reqCycles", 128'(reqCnt), 128'(RUNCYCLES));
        end
        busyCnt = 0;
        reqCnt  = 0;
      end else if (scoreboard.size() != 0 && cyc > scoreboard[0].doneCyc) begin
        checkOutput("doneTimeout", 128'(cyc), 128'(scoreboard[0].doneCyc));
        void'(scoreboard.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] data, input logic enc, input logic [127:0] expected);
    @(negedge clk);
    state_in = data;
    encrypt  = enc;
    start    = 1'b1;
    scoreboard.push_back('{data: expected, doneCyc: cyc + LATENCY});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic disturbRun(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      start    = 1'($urandom);
      encrypt  = ~encrypt;
      state_in = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
  endtask

  initial begin
    logic [127:0] d;
    logic         e;
    rst_n    = 1'b0;
    start    = 1'b0;
    encrypt  = 1'b0;
    state_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] forward single bytes");
    applyStimulus(128'h00530000_00000000_00000000_00000000, 1'b1,
                  128'h63ED6363_63636363_63636363_63636363);
    waitDone(40);

    $display("[TB] forward vector with busy/DONE starts, then back-to-back inverse");
    applyStimulus(128'h00112233445566778899aabbccddeeff, 1'b1,
                  128'h638293c31bfc33f5c4eeacea4bc12816);
    disturbRun(6);
    waitDone(40);
    start    = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0,
                  128'h00112233445566778899aabbccddeeff);
    disturbRun(8);
    waitDone(40);

    $display("[TB] reset in the middle of RUN");
    repeat (2) @(negedge clk);
    applyStimulus(128'h0f0e0d0c0b0a09080706050403020100, 1'b1, '0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    applyStimulus(128'h00112233445566778899aabbccddeeff, 1'b1,
                  128'h638293c31bfc33f5c4eeacea4bc12816);
    waitDone(40);

    $display("[TB] randomized operations");
    for (int t = 0; t < 16; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      e = 1'($urandom);
      applyStimulus(d, e, refSubBytes(d, e));
      if ($urandom_range(0, 1) == 1) disturbRun($urandom_range(1, 10));
      waitDone(40);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboardEmpty", 128'(scoreboard.size()), '0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
